// File: rtl/uart_avmm_pkg.sv
// rtl/uart_avmm_pkg.sv - shared constants and helpers for the UART Avalon-MM master
//
// Contents:
//   ADDR_DATA / ADDR_CTRL      register addresses on the rs232_0 slave
//   RVALID_BIT, RE_BIT, WE_BIT bit positions in the data/control registers
//   FIELD_HI / FIELD_LO        slice of the RAVAIL / WSPACE count fields
//   state_t, ST_*              FSM state encoding
//   ctrl_word(), count_field() register packing / unpacking helpers
package uart_avmm_pkg;

   localparam logic ADDR_DATA = 1'b0;
   localparam logic ADDR_CTRL = 1'b1;

   localparam int RVALID_BIT = 15;
   localparam int RE_BIT     = 0;
   localparam int WE_BIT     = 1;

   // RAVAIL (data reg) and WSPACE (control reg) share the same upper half.
   localparam int FIELD_HI = 31;
   localparam int FIELD_LO = 16;

   typedef logic [FIELD_HI-FIELD_LO:0] count_t;

   typedef logic [2:0] state_t;
   localparam state_t ST_INIT    = 3'd0;
   localparam state_t ST_IDLE    = 3'd1;
   localparam state_t ST_CTRL_RD = 3'd2;
   localparam state_t ST_DATA_WR = 3'd3;
   localparam state_t ST_DATA_RD = 3'd4;
   localparam state_t ST_WAIT    = 3'd5;

   localparam logic [3:0] BE_ALL  = 4'b1111;
   localparam logic [3:0] BE_BYTE = 4'b0001;

   function automatic logic [31:0] ctrl_word(input logic re, input logic we);
      logic [31:0] w;
      w         = '0;
      w[RE_BIT] = re;
      w[WE_BIT] = we;
      return w;
   endfunction

   function automatic count_t count_field(input logic [31:0] w);
      return w[FIELD_HI:FIELD_LO];
   endfunction

endpackage

// File: rtl/uart_avmm_master_if.sv
// rtl/uart_avmm_master_if.sv - Avalon-MM register-port bundle toward the rs232_0 slave
//
// Signals:
//   avm_address     0 = data reg, 1 = control reg
//   avm_chipselect  slave select, one cycle per access
//   avm_byteenable  byte lanes
//   avm_read        read strobe
//   avm_write       write strobe
//   avm_writedata   write data
//   avm_readdata    slave read data, valid the cycle after the read strobe
//   avm_irq         slave interrupt (level)
// Modports: master (this block), slave (the UART or a bench model).
interface uart_avmm_master_if;

   logic        avm_address;
   logic        avm_chipselect;
   logic [3:0]  avm_byteenable;
   logic        avm_read;
   logic        avm_write;
   logic [31:0] avm_writedata;
   logic [31:0] avm_readdata;
   logic        avm_irq;

   modport master (
      output avm_address, avm_chipselect, avm_byteenable,
             avm_read, avm_write, avm_writedata,
      input  avm_readdata, avm_irq
   );

   modport slave (
      input  avm_address, avm_chipselect, avm_byteenable,
             avm_read, avm_write, avm_writedata,
      output avm_readdata, avm_irq
   );

endinterface

// File: rtl/uart_poll_timer.sv
// rtl/uart_poll_timer.sv - saturating idle counter that flags when a poll is due
//
// Ports:
//   clk     clock
//   resetn  synchronous active-low reset
//   en      count this cycle (FSM idle)
//   clr     restart from zero (a read is being issued); wins over en
//   due     count has reached POLL_GAP-1
module uart_poll_timer #(
   parameter int POLL_GAP = 64
) (
   input  logic clk,
   input  logic resetn,
   input  logic en,
   input  logic clr,
   output logic due
);

   localparam int CW = $clog2(POLL_GAP);
   localparam logic [CW-1:0] LIMIT = CW'(POLL_GAP - 1);

   logic [CW-1:0] count;

   // Stops at LIMIT so a long idle stretch cannot wrap back to "not due".
   always_ff @(posedge clk) begin
      if (!resetn) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en && (count != LIMIT)) begin
         count <= count + 1'b1;
      end
   end

   assign due = (count >= LIMIT);

endmodule

// File: rtl/uart_avmm_master.sv
// rtl/uart_avmm_master.sv - byte-stream to polled Avalon-MM bridge for the rs232_0 UART
//
// Build option: UART_AVMM_IRQ_WAIT_EN - rx polling waits on avm_irq instead of the timer.
//
// Ports:
//   clk_clk        system clock
//   reset_reset_n  synchronous active-low reset
//   tx_data        byte to transmit
//   tx_valid       tx_data valid, held until accepted
//   tx_ready       one-cycle accept pulse, coincides with the data write
//   rx_data        received byte
//   rx_valid       rx_data valid, held until rx_ready
//   rx_ready       consumer accepts rx_data
//   avm            Avalon-MM master bundle toward the UART register port
//   busy           FSM is not in IDLE
module uart_avmm_master
   import uart_avmm_pkg::*;
#(
   parameter int POLL_GAP      = 64,
   parameter int RX_IRQ_ENABLE = 0
) (
   input  logic                      clk_clk,
   input  logic                      reset_reset_n,
   input  logic [7:0]                tx_data,
   input  logic                      tx_valid,
   output logic                      tx_ready,
   output logic [7:0]                rx_data,
   output logic                      rx_valid,
   input  logic                      rx_ready,
   uart_avmm_master_if.master        avm,
   output logic                      busy
);

   state_t state;
   logic   rd_is_data;     // the outstanding read targets the data register
   count_t wspace_cache;   // free TX FIFO slots last reported by the UART
   count_t ravail_cache;   // RX bytes still waiting in the UART after the last pop
   logic   last_grant_rx;  // round-robin memory: 1 when rx won the last tx/rx contest

   logic poll_due;
   logic rx_poll;
   logic tx_cand, rx_cand, ctrl_cand;
   logic grant_tx, grant_rx, grant_ctrl;
   logic tmr_en, tmr_clr;
   logic unused_rd;

`ifdef UART_AVMM_IRQ_WAIT_EN
   // Interrupt-driven rx: RE forced on, the level irq replaces the rx poll.
   localparam logic INIT_RE = 1'b1;
   assign rx_poll = avm.avm_irq;
`else
   localparam logic INIT_RE = (RX_IRQ_ENABLE != 0);
   logic unused_irq;
   assign rx_poll    = poll_due;
   assign unused_irq = avm.avm_irq;
`endif

   assign unused_rd = ^avm.avm_readdata[14:8];

   // ------------------------------------------------------------------
   // IDLE arbitration
   // ------------------------------------------------------------------
   assign tx_cand   = tx_valid && (wspace_cache != '0);
   assign rx_cand   = !rx_valid && ((ravail_cache != '0) || rx_poll);
   assign ctrl_cand = tx_valid && (wspace_cache == '0) && poll_due;

   assign grant_tx   = tx_cand && (!rx_cand || last_grant_rx);
   assign grant_rx   = rx_cand && (!tx_cand || !last_grant_rx);
   assign grant_ctrl = ctrl_cand && !tx_cand && !rx_cand;

   assign tmr_en  = (state == ST_IDLE);
   assign tmr_clr = (state == ST_IDLE) && (grant_rx || grant_ctrl);

   uart_poll_timer #(
      .POLL_GAP (POLL_GAP)
   ) u_poll_timer (
      .clk    (clk_clk),
      .resetn (reset_reset_n),
      .en     (tmr_en),
      .clr    (tmr_clr),
      .due    (poll_due)
   );

   assign busy = (state != ST_IDLE);

   // ------------------------------------------------------------------
   // FSM, bus strobes and caches
   // Bus outputs are registered: the strobe is visible during the state
   // named for the access, and the readdata is captured in WAIT.
   // ------------------------------------------------------------------
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         state              <= ST_INIT;
         rd_is_data         <= 1'b0;
         wspace_cache       <= '0;
         ravail_cache       <= '0;
         last_grant_rx      <= 1'b0;
         tx_ready           <= 1'b0;
         rx_valid           <= 1'b0;
         rx_data            <= '0;
         avm.avm_address    <= 1'b0;
         avm.avm_chipselect <= 1'b0;
         avm.avm_byteenable <= '0;
         avm.avm_read       <= 1'b0;
         avm.avm_write      <= 1'b0;
         avm.avm_writedata  <= '0;
      end else begin
         // Strobes and the accept pulse last exactly one cycle.
         avm.avm_chipselect <= 1'b0;
         avm.avm_read       <= 1'b0;
         avm.avm_write      <= 1'b0;
         tx_ready           <= 1'b0;

         if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end

         case (state)
            ST_INIT: begin
               // First cycle issues the control write, second cycle (strobe
               // on the bus) hands over to IDLE.
               if (avm.avm_write) begin
                  state <= ST_IDLE;
               end else begin
                  avm.avm_address    <= ADDR_CTRL;
                  avm.avm_chipselect <= 1'b1;
                  avm.avm_write      <= 1'b1;
                  avm.avm_byteenable <= BE_ALL;
                  avm.avm_writedata  <= ctrl_word(INIT_RE, 1'b0);
               end
            end

            ST_IDLE: begin
               if (grant_tx) begin
                  avm.avm_address    <= ADDR_DATA;
                  avm.avm_chipselect <= 1'b1;
                  avm.avm_write      <= 1'b1;
                  avm.avm_byteenable <= BE_BYTE;
                  avm.avm_writedata  <= {24'b0, tx_data};
                  tx_ready           <= 1'b1;
                  last_grant_rx      <= 1'b0;
                  state              <= ST_DATA_WR;
               end else if (grant_rx) begin
                  avm.avm_address    <= ADDR_DATA;
                  avm.avm_chipselect <= 1'b1;
                  avm.avm_read       <= 1'b1;
                  avm.avm_byteenable <= BE_ALL;
                  rd_is_data         <= 1'b1;
                  last_grant_rx      <= 1'b1;
                  state              <= ST_DATA_RD;
               end else if (grant_ctrl) begin
                  avm.avm_address    <= ADDR_CTRL;
                  avm.avm_chipselect <= 1'b1;
                  avm.avm_read       <= 1'b1;
                  avm.avm_byteenable <= BE_ALL;
                  rd_is_data         <= 1'b0;
                  state              <= ST_CTRL_RD;
               end
            end

            ST_DATA_WR: begin
               wspace_cache <= wspace_cache - 1'b1;
               state        <= ST_IDLE;
            end

            ST_CTRL_RD, ST_DATA_RD: begin
               state <= ST_WAIT;
            end

            ST_WAIT: begin
               if (rd_is_data) begin
                  if (avm.avm_readdata[RVALID_BIT]) begin
                     rx_data      <= avm.avm_readdata[7:0];
                     rx_valid     <= 1'b1;
                     ravail_cache <= count_field(avm.avm_readdata);
                  end else begin
                     ravail_cache <= '0;
                  end
               end else begin
                  wspace_cache <= count_field(avm.avm_readdata);
               end
               state <= ST_IDLE;
            end

            default: begin
               state <= ST_INIT;
            end
         endcase
      end
   end

endmodule
